// File: rtl/psg_atten_scheduler_if.sv
// Mixed-sample output handshake of psg_atten_scheduler.
// The master drives the sample and its valid flag; the slave returns ready.
interface psg_atten_scheduler_if;
  logic signed [15:0] mix;
  logic               mix_valid;
  logic               mix_ready;

  modport master (
    output mix,
    output mix_valid,
    input  mix_ready
  );

  modport slave (
    input  mix,
    input  mix_valid,
    output mix_ready
  );
endinterface

// File: rtl/psg_atten_scheduler.sv
// One shared attenuation multiplier, time-shared across the PSG channels and summed per step.
// Define PSG_NOISE_CH_EN to include the noise channel (ch3) in the mix; otherwise only ch0..ch2.
module psg_atten_scheduler #(
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic [3:0][15:0]       wave_in,
  input  logic                   atten_wr,
  input  logic [1:0]             atten_ch,
  input  logic [3:0]             atten_val,
  psg_atten_scheduler_if.master  mix_if,
  output logic                   busy,
  output logic                   step_drop
);

`ifdef PSG_NOISE_CH_EN
  localparam int unsigned NumCh = 4;
`else
  localparam int unsigned NumCh = 3;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [3:0]        atten_q [4];
  logic [3:0]        code_q  [4];
  logic signed [8:0] base_q  [4];
  logic [1:0]        idx_q, idx_d;

  logic [MULT_LAT-1:0]       pipe_vld_q;
  logic [MULT_LAT-1:0]       pipe_last_q;
  logic [MULT_LAT-1:0][15:0] pipe_term_q;

  logic signed [15:0] acc_q;
  logic signed [15:0] mix_q;

  logic               issue;
  logic               issue_last;
  logic               frame_start;
  logic [7:0]         lut;
  logic [5:0]         mult;
  logic [1:0]         shift;
  logic signed [8:0]  base;
  logic signed [15:0] prod;
  logic signed [15:0] issue_term;
  logic               out_vld;
  logic               out_last;
  logic signed [15:0] out_term;
  logic signed [15:0] acc_sum;

  // Attenuation code -> {mult, shift}; term = (base * mult) >>> shift.
  function automatic logic [7:0] atten_lut(input logic [3:0] code);
    logic [7:0] r;
    case (code)
      4'd0:    r = {6'd32, 2'd0};
      4'd1:    r = {6'd25, 2'd0};
      4'd2:    r = {6'd20, 2'd0};
      4'd3:    r = {6'd16, 2'd0};
      4'd4:    r = {6'd25, 2'd1};
      4'd5:    r = {6'd10, 2'd0};
      4'd6:    r = {6'd8,  2'd0};
      4'd7:    r = {6'd6,  2'd0};
      4'd8:    r = {6'd5,  2'd0};
      4'd9:    r = {6'd4,  2'd0};
      4'd10:   r = {6'd3,  2'd0};
      4'd11:   r = {6'd5,  2'd1};
      4'd12:   r = {6'd2,  2'd0};
      4'd13:   r = {6'd3,  2'd1};
      4'd14:   r = {6'd5,  2'd2};
      default: r = {6'd0,  2'd0};
    endcase
    return r;
  endfunction

  // Shared multiplier front end: operands come from the frame snapshot.
  always_comb begin
    issue      = (state_q == StIssue);
    issue_last = (idx_q == 2'(NumCh - 1));
    lut        = atten_lut(code_q[idx_q]);
    mult       = lut[7:2];
    shift      = lut[1:0];
    base       = base_q[idx_q];
    prod       = $signed({{7{base[8]}}, base}) * $signed({10'd0, mult});
    issue_term = prod >>> shift;
  end

  always_comb begin
    out_vld  = pipe_vld_q[MULT_LAT-1];
    out_last = pipe_last_q[MULT_LAT-1];
    out_term = $signed(pipe_term_q[MULT_LAT-1]);
    acc_sum  = acc_q + out_term;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    step_drop   = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (step) begin
          frame_start = 1'b1;
          idx_d       = 2'd0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        step_drop = step;
        idx_d     = idx_q + 2'd1;
        if (issue_last) state_d = StDrain;
      end
      StDrain: begin
        step_drop = step;
        if (out_vld && out_last) state_d = StDone;
      end
      StDone: begin
        step_drop = step;
        if (mix_if.mix_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy             = (state_q != StIdle);
  assign mix_if.mix_valid = (state_q == StDone);
  assign mix_if.mix       = mix_q;

  // Register-decoder writes land immediately; a running frame keeps its snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) atten_q[i] <= 4'd15;
    end else if (atten_wr) begin
      atten_q[atten_ch] <= atten_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        code_q[i] <= 4'd15;
        base_q[i] <= 9'sd0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < 4; i++) begin
        code_q[i] <= atten_q[i];
        base_q[i] <= $signed(wave_in[i][15:7]);
      end
    end
  end

  // Delay line modelling the multiplier pipeline; the tag marks the frame's last channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      pipe_term_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue && issue_last;
      pipe_term_q[0] <= issue_term;
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
        pipe_term_q[i] <= pipe_term_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      acc_q   <= 16'sd0;
      mix_q   <= 16'sd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (frame_start) begin
        acc_q <= 16'sd0;
      end else if (out_vld) begin
        acc_q <= acc_sum;
        if (out_last) mix_q <= acc_sum;
      end
    end
  end

endmodule
